// File: rtl/draw_sequencer.sv
// ---------------------------------------------------------------------------
// draw_sequencer
//
// Purpose:
//   Sequences a single circle-draw request. On start the request parameters
//   are latched. An optional full-screen clear pass follows, then the
//   downstream circle engine is launched. Its pixel stream is forwarded to the
//   VGA adapter write port through one register stage, with clipping, until
//   the engine reports completion. done is then held until start is released.
//
// Configuration macro:
//   DRAW_SEQUENCER_CLEAR_EN - when defined, the CLEAR pass and its x/y
//   counters are built and IDLE moves to CLEAR on start. When undefined,
//   IDLE moves straight to LAUNCH and no clear pixels are ever produced.
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   start                    request strobe, sampled in IDLE; release it to leave DONE
//   colour, centre_x,
//   centre_y, radius         circle parameters, captured when start is accepted
//   done                     request complete, held until start is sampled low
//   circ_start               run enable for the circle engine (high in DRAW)
//   circ_colour, circ_centre_x,
//   circ_centre_y, circ_radius  latched parameters presented to the circle engine
//   circ_done                circle engine finished
//   circ_x, circ_y,
//   circ_colour_in, circ_plot   pixel stream from the circle engine
//   vga_x, vga_y,
//   vga_colour, vga_plot     registered pixel write port to the VGA adapter
// ---------------------------------------------------------------------------
module draw_sequencer #(
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    output logic       done,
    output logic       circ_start,
    output logic [2:0] circ_colour,
    output logic [7:0] circ_centre_x,
    output logic [6:0] circ_centre_y,
    output logic [7:0] circ_radius,
    input  logic       circ_done,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic [2:0] circ_colour_in,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        DRAW   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Widened screen limits so the clip compare cannot overflow the pixel width.
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

`ifdef DRAW_SEQUENCER_CLEAR_EN
    localparam logic [7:0] X_LAST      = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST      = 7'(SCREEN_H - 1);
    localparam state_t     AFTER_START = CLEAR;
`else
    localparam state_t     AFTER_START = LAUNCH;
`endif

    state_t     state_r;
    logic [2:0] colour_r;
    logic [7:0] centre_x_r;
    logic [6:0] centre_y_r;
    logic [7:0] radius_r;

`ifdef DRAW_SEQUENCER_CLEAR_EN
    logic [7:0] clr_x_r;
    logic [6:0] clr_y_r;
`else
    // The clear colour has no consumer when the clear pass is not built.
    logic [2:0] unused_clear_colour_s;
    assign unused_clear_colour_s = CLEAR_COLOUR;
`endif

    // True when a circle-engine pixel lies inside the visible screen.
    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
        return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    endfunction

    // The circle engine always sees the request captured at start.
    assign circ_colour   = colour_r;
    assign circ_centre_x = centre_x_r;
    assign circ_centre_y = centre_y_r;
    assign circ_radius   = radius_r;

    // Request FSM: parameter capture, clear pass, engine launch, pixel forwarding, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            done       <= 1'b0;
            circ_start <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            colour_r   <= 3'd0;
            centre_x_r <= 8'd0;
            centre_y_r <= 7'd0;
            radius_r   <= 8'd0;
`ifdef DRAW_SEQUENCER_CLEAR_EN
            clr_x_r    <= 8'd0;
            clr_y_r    <= 7'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (start) begin
                        colour_r   <= colour;
                        centre_x_r <= centre_x;
                        centre_y_r <= centre_y;
                        radius_r   <= radius;
`ifdef DRAW_SEQUENCER_CLEAR_EN
                        clr_x_r    <= 8'd0;
                        clr_y_r    <= 7'd0;
`endif
                        state_r    <= AFTER_START;
                    end else begin
                        state_r    <= IDLE;
                    end
                end

`ifdef DRAW_SEQUENCER_CLEAR_EN
                // Column-major sweep: y runs fastest, x advances at the bottom row.
                CLEAR: begin
                    vga_x      <= clr_x_r;
                    vga_y      <= clr_y_r;
                    vga_colour <= CLEAR_COLOUR;
                    vga_plot   <= 1'b1;
                    if (clr_y_r == Y_LAST) begin
                        clr_y_r <= 7'd0;
                        if (clr_x_r == X_LAST) begin
                            clr_x_r <= 8'd0;
                            state_r <= LAUNCH;
                        end else begin
                            clr_x_r <= clr_x_r + 8'd1;
                        end
                    end else begin
                        clr_y_r <= clr_y_r + 7'd1;
                    end
                end
`endif

                LAUNCH: begin
                    vga_plot   <= 1'b0;
                    circ_start <= 1'b1;
                    state_r    <= DRAW;
                end

                // The pixel presented alongside circ_done is still forwarded;
                // it appears on the VGA port during the first DONE cycle.
                DRAW: begin
                    vga_x      <= circ_x;
                    vga_y      <= circ_y;
                    vga_colour <= circ_colour_in;
                    vga_plot   <= circ_plot && on_screen(circ_x, circ_y);
                    if (circ_done) begin
                        circ_start <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        state_r    <= DRAW;
                    end
                end

                DONE: begin
                    vga_plot <= 1'b0;
                    if (!start) begin
                        done    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    done       <= 1'b0;
                    circ_start <= 1'b0;
                    vga_plot   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;

    localparam int         W  = 160;
    localparam int         H  = 120;
    localparam logic [2:0] CC = 3'b000;
`ifdef DRAW_SEQUENCER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic       done;
    logic       circ_start;
    logic [2:0] circ_colour;
    logic [7:0] circ_centre_x;
    logic [6:0] circ_centre_y;
    logic [7:0] circ_radius;
    logic       circ_done;
    logic [7:0] circ_x;
    logic [6:0] circ_y;
    logic [2:0] circ_colour_in;
    logic       circ_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    draw_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOUR(CC)) dut (
        .clk(clk), .rst(rst), .start(start), .colour(colour),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .done(done), .circ_start(circ_start), .circ_colour(circ_colour),
        .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
        .circ_radius(circ_radius), .circ_done(circ_done), .circ_x(circ_x),
        .circ_y(circ_y), .circ_colour_in(circ_colour_in), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The clear pass is modelled as a linear pixel index k; its screen
    // coordinate is x = k / H, y = k % H.
    typedef enum {M_IDLE, M_CLEAR, M_LAUNCH, M_DRAW, M_DONE} mph_t;
    mph_t       ph = M_IDLE;
    int         k = 0;
    bit         model_valid = 1'b0;
    logic [2:0] l_col;
    logic [7:0] l_cx;
    logic [6:0] l_cy;
    logic [7:0] l_r;
    logic       e_plot, e_done, e_start;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
    bit         e_xyc = 1'b0;

    always @(posedge clk) begin
        e_xyc <= 1'b0;
        if (rst) begin
            ph <= M_IDLE; model_valid <= 1'b1;
            l_col <= 3'd0; l_cx <= 8'd0; l_cy <= 7'd0; l_r <= 8'd0;
            e_plot <= 1'b0; e_done <= 1'b0; e_start <= 1'b0;
            e_x <= 8'd0; e_y <= 7'd0; e_col <= 3'd0; e_xyc <= 1'b1;
        end else begin
            case (ph)
                M_IDLE: begin
                    e_plot <= 1'b0;
                    if (start) begin
                        l_col <= colour; l_cx <= centre_x; l_cy <= centre_y; l_r <= radius;
                        k <= 0;
                        ph <= CLR ? M_CLEAR : M_LAUNCH;
                    end
                end
                M_CLEAR: begin
                    e_plot <= 1'b1; e_x <= 8'(k / H); e_y <= 7'(k % H); e_col <= CC; e_xyc <= 1'b1;
                    k <= k + 1;
                    if (k == W * H - 1) ph <= M_LAUNCH;
                end
                M_LAUNCH: begin
                    e_plot <= 1'b0; e_start <= 1'b1; ph <= M_DRAW;
                end
                M_DRAW: begin
                    e_x <= circ_x; e_y <= circ_y; e_col <= circ_colour_in; e_xyc <= 1'b1;
                    e_plot <= circ_plot && (int'(circ_x) < W) && (int'(circ_y) < H);
                    if (circ_done) begin
                        e_start <= 1'b0; e_done <= 1'b1; ph <= M_DONE;
                    end
                end
                M_DONE: begin
                    e_plot <= 1'b0;
                    if (!start) begin
                        e_done <= 1'b0; ph <= M_IDLE;
                    end
                end
                default: ph <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("m_done", done, e_done);
            chk("m_circ_start", circ_start, e_start);
            chk("m_vga_plot", vga_plot, e_plot);
            if (e_xyc) begin
                chk("m_vga_x", vga_x, e_x);
                chk("m_vga_y", vga_y, e_y);
                chk("m_vga_colour", vga_colour, e_col);
            end
            chk("m_circ_centre_x", circ_centre_x, l_cx);
            chk("m_circ_centre_y", circ_centre_y, l_cy);
            chk("m_circ_radius", circ_radius, l_r);
            chk("m_circ_colour", circ_colour, l_col);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic rand_circ();
        circ_x = 8'($urandom); circ_y = 7'($urandom); circ_colour_in = 3'($urandom);
        circ_plot = 1'($urandom); circ_done = 1'($urandom);
    endtask

    task automatic idle_step();
        rand_circ();
        step();
    endtask

    task automatic wait_launch();
        int n = 0;
        while (circ_start !== 1'b1 && n < W * H + 20) begin
            idle_step();
            n++;
        end
        chk("launch_wait", circ_start, 1);
    endtask

    task automatic request(input logic [7:0] cx, input logic [6:0] cy, input logic [7:0] r,
                           input logic [2:0] col);
        centre_x = cx; centre_y = cy; radius = r; colour = col; start = 1'b1;
        idle_step();
        start = 1'($urandom);
        centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom); colour = 3'($urandom);
        idle_step();
        start = 1'b0;
    endtask

    task automatic run_draw(input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            circ_x = 8'($urandom_range(0, 200)); circ_y = 7'($urandom);
            circ_colour_in = 3'($urandom); circ_plot = 1'($urandom_range(0, 3) != 0);
            circ_done = 1'b0;
            step();
        end
        circ_x = 8'($urandom_range(0, 200)); circ_y = 7'($urandom);
        circ_colour_in = 3'($urandom); circ_plot = 1'b1; circ_done = 1'b1; start = st;
        step();
        chk("done_rise", done, 1);
        chk("circ_start_fall", circ_start, 0);
        circ_done = 1'b0;
    endtask

    task automatic finish_req(input int hold);
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            idle_step();
            chk("done_hold", done, 1);
        end
        start = 1'b0;
        idle_step();
        chk("done_fall", done, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   n;
        int   nplots;
        int   lastx;
        int   lasty;
        logic prev;

        rst = 1'b1; start = 1'b0; colour = 3'd0; centre_x = 8'd0; centre_y = 7'd0; radius = 8'd0;
        circ_done = 1'b0; circ_x = 8'd0; circ_y = 7'd0; circ_colour_in = 3'd0; circ_plot = 1'b0;
        step();
        idle_step();
        chk("rst_vga_plot", vga_plot, 0);
        chk("rst_done", done, 0);
        chk("rst_circ_start", circ_start, 0);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_vga_colour", vga_colour, 0);
        chk("rst_centre_x", circ_centre_x, 0);
        chk("rst_radius", circ_radius, 0);
        rst = 1'b0;

        // Directed request: centre (80,60), r=40, colour 010.
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'b010; start = 1'b1;
        idle_step();
        start = 1'b0;
        centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom); colour = 3'($urandom);
        chk("entry_plot", vga_plot, 0);
        chk("entry_circ_start", circ_start, 0);
        if (CLR) begin
            idle_step();
            chk("clr_first_plot", vga_plot, 1);
            chk("clr_first_x", vga_x, 0);
            chk("clr_first_y", vga_y, 0);
            chk("clr_first_colour", vga_colour, 0);
            nplots = 1; lastx = 0; lasty = 0; prev = 1'b1; n = 0;
            while (circ_start !== 1'b1 && n < W * H + 20) begin
                prev = vga_plot;
                idle_step();
                n++;
                if (vga_plot === 1'b1) begin
                    nplots++; lastx = int'(vga_x); lasty = int'(vga_y);
                end
            end
            chk("clr_count", nplots, 19200);
            chk("clr_last_x", lastx, 159);
            chk("clr_last_y", lasty, 119);
            chk("launch_after_last_clear", prev, 1);
            chk("launch_circ_start", circ_start, 1);
        end else begin
            idle_step();
            chk("launch_circ_start", circ_start, 1);
            chk("launch_no_plot", vga_plot, 0);
        end
        chk("lat_centre_x", circ_centre_x, 80);
        chk("lat_centre_y", circ_centre_y, 60);
        chk("lat_radius", circ_radius, 40);
        chk("lat_colour", circ_colour, 2);

        // Forwarding and clipping.
        circ_done = 1'b0; circ_x = 8'd120; circ_y = 7'd60; circ_colour_in = 3'b101; circ_plot = 1'b1;
        step();
        chk("pix_in_plot", vga_plot, 1);
        chk("pix_in_x", vga_x, 120);
        chk("pix_in_y", vga_y, 60);
        chk("pix_in_colour", vga_colour, 5);
        circ_x = 8'd170;
        step();
        chk("pix_clip_x_plot", vga_plot, 0);
        chk("pix_clip_x_raw", vga_x, 170);
        circ_x = 8'd100; circ_y = 7'd125;
        step();
        chk("pix_clip_y_plot", vga_plot, 0);
        chk("pix_clip_y_raw", vga_y, 125);
        run_draw(20, 1'b1);
        finish_req(3);

        // Reset in the middle of the clear pass, then restart.
        if (CLR) begin
            centre_x = 8'd10; centre_y = 7'd10; radius = 8'd5; colour = 3'd7; start = 1'b1;
            idle_step();
            start = 1'b0;
            for (int i = 0; i < 500; i++) idle_step();
            chk("mid_clear_plotting", vga_plot, 1);
            rst = 1'b1;
            idle_step();
            chk("clr_abort_plot", vga_plot, 0);
            chk("clr_abort_circ_start", circ_start, 0);
            rst = 1'b0; start = 1'b1;
            idle_step();
            start = 1'b0;
            idle_step();
            chk("restart_plot", vga_plot, 1);
            chk("restart_x", vga_x, 0);
            chk("restart_y", vga_y, 0);
            rst = 1'b1;
            idle_step();
            rst = 1'b0;
        end

        // Reset in the middle of the draw.
        request(8'd50, 7'd40, 8'd20, 3'd4);
        wait_launch();
        for (int i = 0; i < 5; i++) begin
            circ_x = 8'(10 + i); circ_y = 7'd10; circ_plot = 1'b1; circ_done = 1'b0;
            step();
        end
        chk("mid_draw_plotting", vga_plot, 1);
        rst = 1'b1;
        idle_step();
        chk("draw_abort_plot", vga_plot, 0);
        chk("draw_abort_circ_start", circ_start, 0);
        chk("draw_abort_done", done, 0);
        rst = 1'b0;
        idle_step();

        // Randomised requests.
        for (int r = 0; r < (CLR ? 1 : 12); r++) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) idle_step();
            request(8'($urandom), 7'($urandom), 8'($urandom), 3'($urandom));
            wait_launch();
            run_draw(int'($urandom_range(3, 40)), 1'($urandom));
            finish_req(int'($urandom_range(0, 3)));
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
